adder_prefix_pipe: RTL and testbench

ADDER_PREFIX_PIPE -- requirements
Module: adder_prefix_pipe

---
 rtl/adder_prefix_pipe_pkg.sv | 35 +++
 rtl/adder_prefix_level.sv | 30 +++
 rtl/gp_cell.sv | 14 +
 rtl/adder_prefix_pipe.sv | 166 ++++++++++++++++
 tb/tb_adder_prefix_pipe.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_prefix_pipe_pkg.sv
// Shared ALU definitions: operation encodings, flag bundle and operand-conditioning helpers
// used by the pipelined prefix adder.
package adder_prefix_pipe_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ADC = 2'd2,
      OP_SBB = 2'd3
   } alu_op_e;

   typedef struct packed {
      logic c_out;
      logic ovf;
      logic zero;
      logic neg;
   } alu_flags_t;

   function automatic logic op_inverts_b(input alu_op_e op);
      return (op == OP_SUB) || (op == OP_SBB);
   endfunction

   // Subtraction is a + ~b + 1, so borrow-in maps to an inverted carry seed.
   function automatic logic carry_seed(input alu_op_e op, input logic cin);
      logic c0;
      case (op)
         OP_ADD:  c0 = 1'b0;
         OP_SUB:  c0 = 1'b1;
         OP_ADC:  c0 = cin;
         default: c0 = ~cin;
      endcase
      return c0;
   endfunction

endpackage

// File: rtl/adder_prefix_level.sv
// One Sklansky level: bits with index bit LEVEL set merge with the top bit of the block
// just below them; every other bit passes straight through.
module adder_prefix_level #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned LEVEL = 0
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : bit_g
      if (((i >> LEVEL) & 1) != 0) begin : merge
         localparam int J = ((i >> LEVEL) << LEVEL) - 1;
         gp_cell u_cell (
            .g_hi (g_in[i]),
            .p_hi (p_in[i]),
            .g_lo (g_in[J]),
            .p_lo (p_in[J]),
            .g    (g_out[i]),
            .p    (p_out[i])
         );
      end else begin : pass
         assign g_out[i] = g_in[i];
         assign p_out[i] = p_in[i];
      end
   end

endmodule

// File: rtl/gp_cell.sv
// Prefix operator: merges a higher (g,p) group with the adjacent lower group.
module gp_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);

   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;

endmodule

// File: rtl/adder_prefix_pipe.sv
// Pipelined Sklansky adder/subtractor with valid/ready flow control; a register slice is
// placed after each prefix level selected by PIPE_MASK, followed by a fixed output stage.
module adder_prefix_pipe
   import adder_prefix_pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned PIPE_MASK = 32'b101010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned LEVELS = $clog2(WIDTH);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] g_0;
   logic [WIDTH-1:0] p_0;
   logic             c0_0;
   logic             out_rdy;

   // The seed carry is folded into bit 0 as a generate, so the tree output G[i] is the
   // carry out of bit i including c0.
   always_comb begin
      b_eff  = op_inverts_b(alu_op_e'(op)) ? ~b : b;
      c0_0   = carry_seed(alu_op_e'(op), cin);
      p_0    = a ^ b_eff;
      g_0    = a & b_eff;
      g_0[0] = g_0[0] | (p_0[0] & c0_0);
   end

   for (genvar k = 0; k < LEVELS; k++) begin : lvl
      logic [WIDTH-1:0] g_i, pp_i, p0_i;
      logic [WIDTH-1:0] g_c, pp_c;
      logic [WIDTH-1:0] g_o, pp_o, p0_o;
      logic             c0_i, c0_o;
      logic             vld_i, vld_o;
      logic             rdy_i, rdy_o;

      if (k == 0) begin : src
         assign g_i   = g_0;
         assign pp_i  = p_0;
         assign p0_i  = p_0;
         assign c0_i  = c0_0;
         assign vld_i = in_valid;
      end else begin : src
         assign g_i   = lvl[k-1].g_o;
         assign pp_i  = lvl[k-1].pp_o;
         assign p0_i  = lvl[k-1].p0_o;
         assign c0_i  = lvl[k-1].c0_o;
         assign vld_i = lvl[k-1].vld_o;
      end

      if (k == LEVELS - 1) begin : dst
         assign rdy_o = out_rdy;
      end else begin : dst
         assign rdy_o = lvl[k+1].rdy_i;
      end

      adder_prefix_level #(
         .WIDTH (WIDTH),
         .LEVEL (k)
      ) u_level (
         .g_in  (g_i),
         .p_in  (pp_i),
         .g_out (g_c),
         .p_out (pp_c)
      );

      if (((PIPE_MASK >> k) & 1) != 0) begin : pipe
         logic             vld_q;
         logic             c0_q;
         logic [WIDTH-1:0] g_q, pp_q, p0_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= 1'b0;
            end else if (rdy_i) begin
               vld_q <= vld_i;
            end
         end

         // Data slices carry no reset; the valid bit alone qualifies them.
         always_ff @(posedge clk) begin
            if (vld_i && rdy_i) begin
               g_q  <= g_c;
               pp_q <= pp_c;
               p0_q <= p0_i;
               c0_q <= c0_i;
            end
         end

         assign rdy_i = !vld_q || rdy_o;
         assign vld_o = vld_q;
         assign g_o   = g_q;
         assign pp_o  = pp_q;
         assign p0_o  = p0_q;
         assign c0_o  = c0_q;
      end else begin : pipe
         assign rdy_i = rdy_o;
         assign vld_o = vld_i;
         assign g_o   = g_c;
         assign pp_o  = pp_c;
         assign p0_o  = p0_i;
         assign c0_o  = c0_i;
      end
   end

   logic [WIDTH-1:0] g_f;
   logic [WIDTH-1:0] p0_f;
   logic             c0_f;
   logic             vld_f;
   logic [WIDTH-1:0] sum_n;
   alu_flags_t       flags_n;
   alu_flags_t       flags_q;
   logic             unused_pp;

   assign g_f       = lvl[LEVELS-1].g_o;
   assign p0_f      = lvl[LEVELS-1].p0_o;
   assign c0_f      = lvl[LEVELS-1].c0_o;
   assign vld_f     = lvl[LEVELS-1].vld_o;
   assign unused_pp = ^lvl[LEVELS-1].pp_o;

   always_comb begin
      sum_n         = p0_f ^ {g_f[WIDTH-2:0], c0_f};
      flags_n.c_out = g_f[WIDTH-1];
      flags_n.ovf   = g_f[WIDTH-1] ^ g_f[WIDTH-2];
      flags_n.zero  = (sum_n == '0);
      flags_n.neg   = sum_n[WIDTH-1];
   end

   assign out_rdy = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         flags_q   <= '0;
      end else if (out_rdy) begin
         out_valid <= vld_f;
         if (vld_f) begin
            sum     <= sum_n;
            flags_q <= flags_n;
         end
      end
   end

   assign c_out    = flags_q.c_out;
   assign ovf      = flags_q.ovf;
   assign zero     = flags_q.zero;
   assign neg      = flags_q.neg;
   assign in_ready = !rst && lvl[0].rdy_i;

endmodule

// File: tb/tb_adder_prefix_pipe.sv
// Bench for adder_prefix_pipe: directed corner ops, latency sweep over three pipe masks,
// randomized streams under steady and random back-pressure, and mid-flight reset.
module tb_adder_prefix_pipe;

   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovf;
      logic         zero;
      logic         neg;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b;
   logic         cin;
   logic [1:0]   op;
   logic         out_ready;
   logic         iv_m, iv_z, iv_f;

   logic         ir_m, ov_m, co_m, vf_m, z_m, n_m;
   logic         ir_z, ov_z, co_z, vf_z, z_z, n_z;
   logic         ir_f, ov_f, co_f, vf_f, z_f, n_f;
   logic [W-1:0] sum_m, sum_z, sum_f;
   res_t         res_m, res_z, res_f;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   adder_prefix_pipe #(.WIDTH(W), .PIPE_MASK(32'b101010)) dut_m (
      .clk(clk), .rst(rst), .in_valid(iv_m), .in_ready(ir_m), .a(a), .b(b), .cin(cin), .op(op),
      .out_valid(ov_m), .out_ready(out_ready), .sum(sum_m), .c_out(co_m), .ovf(vf_m),
      .zero(z_m), .neg(n_m));

   adder_prefix_pipe #(.WIDTH(W), .PIPE_MASK(32'b0)) dut_z (
      .clk(clk), .rst(rst), .in_valid(iv_z), .in_ready(ir_z), .a(a), .b(b), .cin(cin), .op(op),
      .out_valid(ov_z), .out_ready(out_ready), .sum(sum_z), .c_out(co_z), .ovf(vf_z),
      .zero(z_z), .neg(n_z));

   adder_prefix_pipe #(.WIDTH(W), .PIPE_MASK(32'b111111)) dut_f (
      .clk(clk), .rst(rst), .in_valid(iv_f), .in_ready(ir_f), .a(a), .b(b), .cin(cin), .op(op),
      .out_valid(ov_f), .out_ready(out_ready), .sum(sum_f), .c_out(co_f), .ovf(vf_f),
      .zero(z_f), .neg(n_f));

   assign res_m = {sum_m, co_m, vf_m, z_m, n_m};
   assign res_z = {sum_z, co_z, vf_z, z_z, n_z};
   assign res_f = {sum_f, co_f, vf_f, z_f, n_f};

   // Reference: plain wide-integer arithmetic; overflow from operand/result signs.
   function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic ci);
      logic [W-1:0] yy;
      logic         c0;
      logic [W:0]   t;
      res_t         r;
      case (o)
         2'd0:    begin yy = y;  c0 = 1'b0; end
         2'd1:    begin yy = ~y; c0 = 1'b1; end
         2'd2:    begin yy = y;  c0 = ci;   end
         default: begin yy = ~y; c0 = ~ci;  end
      endcase
      t       = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
      r.sum   = t[W-1:0];
      r.c_out = t[W];
      r.ovf   = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      r.zero  = (t[W-1:0] == '0);
      r.neg   = t[W-1];
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_operands();
      a   = {$urandom(), $urandom()};
      op  = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
         0:       b = a;
         1:       b = ~a;
         default: b = {$urandom(), $urandom()};
      endcase
   endtask

   task automatic single(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, input res_t exp);
      int lat;
      out_ready = 1'b1;
      op = o; a = x; b = y; cin = ci;
      iv_m = 1'b1;
      #1;
      check({tag, "_in_ready"}, 128'(ir_m), 128'(1'b1));
      step();
      iv_m = 1'b0;
      lat = 1;
      while (!ov_m && lat < 50) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 128'(lat), 128'(4));
      check({tag, "_result"}, 128'(res_m), 128'(exp));
      check({tag, "_model"}, 128'(res_m), 128'(model(o, x, y, ci)));
      step();
   endtask

   task automatic run_stream(input string tag, input int n, input bit rnd);
      res_t q[$];
      res_t held;
      res_t exp;
      int   sent = 0, got = 0, cyc = 0, first = -1, last = -1;
      bit   stalled = 0, acc, del;
      rand_operands();
      iv_m = 1'b1;
      while (got < n && cyc < 4000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled)
            check({tag, "_hold"}, 128'({ov_m, res_m}), 128'({1'b1, held}));
         acc = iv_m && ir_m;
         del = ov_m && out_ready;
         if (del) begin
            if (q.size() == 0) begin
               check({tag, "_extra"}, 128'(ov_m), 128'(1'b0));
            end else begin
               exp = q.pop_front();
               check({tag, "_data"}, 128'(res_m), 128'(exp));
               got++;
               if (first < 0) first = cyc;
               last = cyc;
            end
         end
         if (acc) begin
            q.push_back(model(op, a, b, cin));
            sent++;
         end
         stalled = ov_m && !out_ready;
         held    = res_m;
         step();
         cyc++;
         if (acc) begin
            if (sent < n) rand_operands();
            else iv_m = 1'b0;
         end
      end
      iv_m = 1'b0;
      check({tag, "_count"}, 128'(got), 128'(n));
      check({tag, "_leftover"}, 128'(q.size()), 128'(0));
      if (!rnd)
         check({tag, "_rate"}, 128'(last - first + 1), 128'(n));
      out_ready = 1'b1;
      step();
   endtask

   initial begin
      int   lm, lz, lf;
      res_t exp;

      rst = 1'b1; iv_m = 1'b0; iv_z = 1'b0; iv_f = 1'b0;
      a = '0; b = '0; cin = 1'b0; op = 2'd0; out_ready = 1'b1;
      step();
      step();
      check("reset_in_ready", 128'(ir_m), 128'(1'b0));
      check("reset_outputs", 128'({ov_m, res_m}), 128'(0));
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", 128'(ir_m), 128'(1'b1));
      step();

      single("add_wrap", 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             '{sum: 64'd0, c_out: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0});
      single("sub_ovf", 2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
             '{sum: 64'h7FFF_FFFF_FFFF_FFFF, c_out: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b0});
      single("sbb_borrow", 2'd3, 64'd5, 64'd5, 1'b1,
             '{sum: 64'hFFFF_FFFF_FFFF_FFFF, c_out: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1});
      single("adc_carry", 2'd2, 64'd5, 64'd5, 1'b1,
             '{sum: 64'd11, c_out: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});

      // Latency sweep: one op launched into all three mask variants together.
      out_ready = 1'b1;
      rand_operands();
      exp = model(op, a, b, cin);
      iv_m = 1'b1; iv_z = 1'b1; iv_f = 1'b1;
      step();
      iv_m = 1'b0; iv_z = 1'b0; iv_f = 1'b0;
      lm = 0; lz = 0; lf = 0;
      for (int c = 1; c <= 20; c++) begin
         if (ov_m && lm == 0) begin lm = c; check("sweep_res_m", 128'(res_m), 128'(exp)); end
         if (ov_z && lz == 0) begin lz = c; check("sweep_res_z", 128'(res_z), 128'(exp)); end
         if (ov_f && lf == 0) begin lf = c; check("sweep_res_f", 128'(res_f), 128'(exp)); end
         step();
      end
      check("latency_mask0", 128'(lz), 128'(1));
      check("latency_mask111111", 128'(lf), 128'(7));
      check("latency_mask101010", 128'(lm), 128'(4));

      run_stream("stream_full", 100, 1'b0);
      run_stream("stream_bp", 100, 1'b1);

      // Reset with three ops stuck behind a stalled output.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_operands();
         iv_m = 1'b1;
         step();
      end
      iv_m = 1'b0;
      step();
      step();
      check("stalled_before_rst", 128'(ov_m), 128'(1'b1));
      rst = 1'b1;
      #1;
      check("rst_in_ready", 128'(ir_m), 128'(1'b0));
      step();
      check("rst_clears_outputs", 128'({ov_m, res_m}), 128'(0));
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", 128'(ir_m), 128'(1'b1));
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("no_stale_result", 128'(ov_m), 128'(1'b0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
